rv32m_mul_issue: RTL and testbench
==================================

RV32M_MUL_ISSUE -- requirements
Module: rv32m_mul_issue

Interface
REQ-001 SHALL: clk_i  in  1  single clock; all state changes on the rising edge.
REQ-002 SHALL: rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: valid_i  in  1  core presents an M-extension multiply request.
REQ-004 SHALL: ready_o  out  1  block can accept a request.
REQ-005 SHALL: funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx illegal here.
REQ-006 SHALL: rs1_i, rs2_i  in  32 each  source operands.
REQ-007 SHALL: mult_en_o  out  1  enable to the unsigned multiplier core.
REQ-008 SHALL: op_a_o, op_b_o  out  32 each  unsigned operand magnitudes to the core.
REQ-009 SHALL: mul_clr_o  out  1  one-cycle synchronous clear that returns the core to its initial state.
REQ-010 SHALL: done_i  in  1  core finished; product_i is valid while done_i=1.
REQ-011 SHALL: product_i  in  64  unsigned product from the core.
REQ-012 SHALL: result_o  out  32  final rd value.
REQ-013 SHALL: result_valid_o  out  1  result_o/err_o valid.
REQ-014 SHALL: result_ready_i  in  1  core consumes the result.
REQ-015 SHALL: err_o  out  1  request was illegal or timed out; result_o=0.
REQ-016 SHALL: parameter WDOG_MAX, default 31, is the maximum number of BUSY cycles before abort.

Function
REQ-017 SHALL: states IDLE, PREP, BUSY, FIX, RESP.
REQ-018 SHALL: ready_o=1 only in IDLE; a request is accepted on valid_i&ready_o, registering rs1, rs2 and funct3.
REQ-019 SHALL: on accept with funct3[2]=0, go IDLE->PREP; with funct3[2]=1, go IDLE->RESP with err_o=1 and result_o=0, without asserting mult_en_o.
REQ-020 SHALL: signedness is sa=(funct3==001|010) and sb=(funct3==001); MUL and MULHU are treated as unsigned.
REQ-021 SHALL: in PREP, register op_a = sa&rs1[31] ? -rs1 : rs1 (32-bit two's complement), op_b likewise with sb/rs2, and neg=(sa&rs1[31])^(sb&rs2[31]); 0x80000000 maps to magnitude 0x80000000.
REQ-022 SHALL: PREP->BUSY unconditionally after one cycle.
REQ-023 SHALL: in BUSY, mult_en_o=1 and op_a_o/op_b_o are held stable; the 5-bit watchdog counter starts at 0 and increments each BUSY cycle.
REQ-024 SHALL: on done_i=1 in BUSY, capture product_i and go to FIX; mult_en_o=0 from FIX onward.
REQ-025 SHALL: if the watchdog reaches WDOG_MAX with done_i=0, go BUSY->RESP with err_o=1 and result_o=0; if done_i=1 in that same cycle, done_i wins.
REQ-026 SHALL: mul_clr_o pulses for exactly one cycle on the cycle after leaving BUSY (by done or by timeout), and is 0 at all other times.
REQ-027 SHALL: in FIX, compute p = neg ? -product (64-bit) : product; result = p[31:0] for MUL, else p[63:32]; FIX->RESP after one cycle.
REQ-028 SHALL: in RESP, result_valid_o=1 with result_o/err_o held stable until result_ready_i=1, then go to IDLE; result_ready_i is ignored outside RESP.
REQ-029 SHALL: accept-to-result_valid_o latency equals 3 + N cycles for a core that asserts done_i N cycles after mult_en_o rises, and 1 cycle for illegal funct3.
REQ-030 SHALL: valid_i outside IDLE is ignored; there is no request queuing.

Reset
REQ-031 SHALL: while rst_ni=0, the state is IDLE and all outputs are 0, including ready_o, mult_en_o, mul_clr_o, result_valid_o, err_o, result_o, op_a_o and op_b_o.
REQ-032 SHALL: a reset asserted mid-operation abandons the operation immediately; the first cycle after release has ready_o=1, and no result is delivered for the abandoned request.
REQ-033 SHALL: the multiplier core shares rst_ni, so no mul_clr_o pulse is required after reset.

Verification
REQ-034 SHALL: MUL rs1=7, rs2=0xFFFFFFFD -> result_o=0xFFFFFFEB, err_o=0, exactly one mul_clr_o pulse.
REQ-035 SHALL: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 SHALL: MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; with a core model of N=7, result_valid_o rises exactly 10 cycles after accept.
REQ-037 SHALL: funct3=100 -> result_valid_o one cycle after accept, err_o=1, result_o=0, mult_en_o never asserted.
REQ-038 SHALL: core never asserts done_i -> after 31 BUSY cycles, err_o=1, result_o=0, one mul_clr_o pulse; a second case with done_i on cycle 31 returns the normal result.
REQ-039 SHALL: result_ready_i held 0 for 5 cycles -> result_o stable and ready_o=0 throughout; rst_ni pulsed low during BUSY -> all outputs 0, and the next request completes correctly.

Source files
------------

// File: rtl/rv32m_mul_issue_if.sv
// Handshake bundle between the issuing core, the RV32M multiply sequencer and the
// unsigned multiplier core.
interface rv32m_mul_issue_if;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        mult_en_o;
   logic [31:0] op_a_o;
   logic [31:0] op_b_o;
   logic        mul_clr_o;
   logic        done_i;
   logic [63:0] product_i;
   logic [31:0] result_o;
   logic        result_valid_o;
   logic        result_ready_i;
   logic        err_o;

   modport slave (
      input  valid_i, funct3_i, rs1_i, rs2_i, done_i, product_i, result_ready_i,
      output ready_o, mult_en_o, op_a_o, op_b_o, mul_clr_o, result_o, result_valid_o, err_o
   );

   modport master (
      output valid_i, funct3_i, rs1_i, rs2_i, done_i, product_i, result_ready_i,
      input  ready_o, mult_en_o, op_a_o, op_b_o, mul_clr_o, result_o, result_valid_o, err_o
   );
endinterface

// File: rtl/rv32m_mul_issue.sv
// RV32M MUL/MULH/MULHSU/MULHU sequencer: converts signed operands to magnitudes for an
// unsigned multiplier core, watches it with a watchdog and re-applies the sign.
module rv32m_mul_issue #(
   parameter int unsigned WDOG_MAX = 31
) (
   input logic               clk_i,
   input logic               rst_ni,
   rv32m_mul_issue_if.slave  bus
);

   typedef enum logic [2:0] {StIdle, StPrep, StBusy, StFix, StResp} state_e;

   // Timeout fires in the BUSY cycle whose increment makes the counter reach WDOG_MAX.
   localparam logic [4:0] WdogLast = 5'(WDOG_MAX - 1);

   state_e      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] rs1_q, rs1_d;
   logic [31:0] rs2_q, rs2_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic        neg_q, neg_d;
   logic [63:0] product_q, product_d;
   logic [4:0]  wdog_q, wdog_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;
   logic        mul_clr_q, mul_clr_d;

   logic        sa, sb;
   logic [63:0] prod_fix;

   assign sa       = (funct3_q[1:0] == 2'b01) || (funct3_q[1:0] == 2'b10);
   assign sb       = (funct3_q[1:0] == 2'b01);
   assign prod_fix = neg_q ? (~product_q + 64'd1) : product_q;

   always_comb begin
      state_d   = state_q;
      funct3_d  = funct3_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      neg_d     = neg_q;
      product_d = product_q;
      wdog_d    = wdog_q;
      result_d  = result_q;
      err_d     = err_q;
      unique case (state_q)
         StIdle: begin
            if (bus.valid_i) begin
               funct3_d = bus.funct3_i;
               rs1_d    = bus.rs1_i;
               rs2_d    = bus.rs2_i;
               result_d = '0;
               err_d    = bus.funct3_i[2];
               state_d  = bus.funct3_i[2] ? StResp : StPrep;
            end
         end
         StPrep: begin
            op_a_d  = (sa && rs1_q[31]) ? (~rs1_q + 32'd1) : rs1_q;
            op_b_d  = (sb && rs2_q[31]) ? (~rs2_q + 32'd1) : rs2_q;
            neg_d   = (sa && rs1_q[31]) ^ (sb && rs2_q[31]);
            wdog_d  = '0;
            state_d = StBusy;
         end
         StBusy: begin
            wdog_d = wdog_q + 5'd1;
            if (bus.done_i) begin
               product_d = bus.product_i;
               state_d   = StFix;
            end else if (wdog_q == WdogLast) begin
               err_d    = 1'b1;
               result_d = '0;
               state_d  = StResp;
            end
         end
         StFix: begin
            result_d = (funct3_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
            state_d  = StResp;
         end
         StResp: begin
            if (bus.result_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      mul_clr_d = (state_q == StBusy) && (state_d != StBusy);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         funct3_q  <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         wdog_q    <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
         mul_clr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         funct3_q  <= funct3_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         neg_q     <= neg_d;
         product_q <= product_d;
         wdog_q    <= wdog_d;
         result_q  <= result_d;
         err_q     <= err_d;
         mul_clr_q <= mul_clr_d;
      end
   end

   // ready_o is gated by reset so it reads 0 while reset is held.
   assign bus.ready_o        = (state_q == StIdle) && rst_ni;
   assign bus.mult_en_o      = (state_q == StBusy);
   assign bus.op_a_o         = op_a_q;
   assign bus.op_b_o         = op_b_q;
   assign bus.mul_clr_o      = mul_clr_q;
   assign bus.result_valid_o = (state_q == StResp);
   assign bus.result_o       = result_q;
   assign bus.err_o          = err_q && (state_q == StResp);

endmodule

// File: tb/tb_rv32m_mul_issue.sv
// Scoreboard bench for rv32m_mul_issue with a behavioural multiplier core that raises
// done_i in its Nth enabled cycle (N=0 means never).
module tb_rv32m_mul_issue;

   logic clk;
   logic rst_n;

   rv32m_mul_issue_if bus ();

   rv32m_mul_issue #(
      .WDOG_MAX(31)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        err;
      int          lat;
      int          en;
      int          clr;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Core model
   int core_n = 0;
   int core_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)              core_cnt <= 0;
      else if (bus.mul_clr_o)  core_cnt <= 0;
      else if (bus.mult_en_o)  core_cnt <= core_cnt + 1;
   end
   assign bus.done_i    = bus.mult_en_o && (core_n != 0) && (core_cnt == core_n - 1);
   assign bus.product_i = {32'd0, bus.op_a_o} * {32'd0, bus.op_b_o};

   int clr_total = 0;
   int en_total  = 0;
   always @(negedge clk) begin
      if (bus.mul_clr_o === 1'b1) clr_total <= clr_total + 1;
      if (bus.mult_en_o === 1'b1) en_total  <= en_total + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] xa, xb, p;
      xa = (f3[1:0] == 2'b01 || f3[1:0] == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
      xb = (f3[1:0] == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = xa * xb;
      return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ready"},   64'(bus.ready_o), 0);
      check({tag, "_mult_en"}, 64'(bus.mult_en_o), 0);
      check({tag, "_mul_clr"}, 64'(bus.mul_clr_o), 0);
      check({tag, "_rvalid"},  64'(bus.result_valid_o), 0);
      check({tag, "_err"},     64'(bus.err_o), 0);
      check({tag, "_result"},  64'(bus.result_o), 0);
      check({tag, "_op_a"},    64'(bus.op_a_o), 0);
      check({tag, "_op_b"},    64'(bus.op_b_o), 0);
   endtask

   task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int n, input int hold);
      exp_t e, got;
      int   lat, clr0, en0;
      @(negedge clk);
      check("ready_before", 64'(bus.ready_o), 1);
      e.err = f3[2] || (n == 0);
      e.res = e.err ? 32'd0 : golden(f3, a, b);
      e.lat = f3[2] ? 1 : (n == 0) ? 33 : 3 + n;
      e.en  = f3[2] ? 0 : (n == 0) ? 31 : n;
      e.clr = f3[2] ? 0 : 1;
      sb_q.push_back(e);
      core_n       = n;
      clr0         = clr_total;
      en0          = en_total;
      bus.valid_i  = 1'b1;
      bus.funct3_i = f3;
      bus.rs1_i    = a;
      bus.rs2_i    = b;
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      lat = 1;
      @(negedge clk);
      while (bus.result_valid_o !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      got = sb_q.pop_front();
      if (bus.result_valid_o !== 1'b1) begin
         check("result_valid_timeout", 64'(bus.result_valid_o), 1);
         return;
      end
      check("latency", 64'(lat), 64'(got.lat));
      check("result", 64'(bus.result_o), 64'(got.res));
      check("err", 64'(bus.err_o), 64'(got.err));
      repeat (hold) begin
         @(negedge clk);
         check("hold_result", 64'(bus.result_o), 64'(got.res));
         check("hold_valid", 64'(bus.result_valid_o), 1);
         check("hold_ready", 64'(bus.ready_o), 0);
      end
      bus.result_ready_i = 1'b1;
      @(posedge clk);
      #1 bus.result_ready_i = 1'b0;
      @(negedge clk);
      check("ready_after", 64'(bus.ready_o), 1);
      check("rvalid_after", 64'(bus.result_valid_o), 0);
      check("mul_clr_pulses", 64'(clr_total - clr0), 64'(got.clr));
      check("mult_en_cycles", 64'(en_total - en0), 64'(got.en));
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.valid_i        = 1'b0;
      bus.funct3_i       = '0;
      bus.rs1_i          = '0;
      bus.rs2_i          = '0;
      bus.result_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;
      #1 check("ready_post_reset", 64'(bus.ready_o), 1);

      run_req(3'b000, 32'd7, 32'hFFFF_FFFD, 3, 0);          // MUL -> FFFFFFEB
      run_req(3'b001, 32'h8000_0000, 32'h8000_0000, 2, 0);   // MULH -> 40000000
      run_req(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0);   // MULHU -> FFFFFFFE
      run_req(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 0);   // MULHSU, latency 10
      run_req(3'b100, 32'h1234_5678, 32'h9ABC_DEF0, 4, 0);   // illegal
      run_req(3'b111, 32'hFFFF_FFFF, 32'd1, 4, 1);           // illegal
      run_req(3'b000, 32'd5, 32'd6, 0, 0);                   // watchdog timeout
      run_req(3'b001, 32'hFFFF_FFF0, 32'd3, 31, 0);          // done on last BUSY cycle
      run_req(3'b000, 32'hDEAD_BEEF, 32'h0000_1234, 1, 5);   // consumer stalls 5 cycles
      run_req(3'b010, 32'h8000_0000, 32'h8000_0000, 2, 0);
      for (int i = 0; i < 6; i++) begin
         run_req(3'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(1, 8)), 0);
      end

      // Reset during BUSY abandons the request; no result may appear afterwards.
      @(negedge clk);
      core_n       = 0;
      bus.valid_i  = 1'b1;
      bus.funct3_i = 3'b001;
      bus.rs1_i    = 32'h1111_1111;
      bus.rs2_i    = 32'h2222_2222;
      @(posedge clk);
      #1 bus.valid_i = 1'b0;
      repeat (5) @(negedge clk);
      check("busy_before_reset", 64'(bus.mult_en_o), 1);
      rst_n = 1'b0;
      #1 check_outputs_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("ready_after_release", 64'(bus.ready_o), 1);
      repeat (4) begin
         @(negedge clk);
         check("no_stale_result", 64'(bus.result_valid_o), 0);
      end
      run_req(3'b000, 32'd7, 32'hFFFF_FFFD, 4, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
